// File: rtl/snn_mem_arbiter_pkg.sv
// Shared definitions for the SNN weight-memory arbiter: default widths, limits and FSM state type.
package snn_pkg;

  localparam int ADDR_W_DEF     = 2;
  localparam int DW_DEF         = 8;
  localparam int RD_LAT_DEF     = 1;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    WB_RESP = 2'd3
  } arb_state_t;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/snn_mem_arbiter_if.sv
// Request/response and memory bus of the weight-memory arbiter.
// slave = arbiter side, master = requesters plus the memory macro.
interface snn_mem_arbiter_if
  import snn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DW     = DW_DEF
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;

  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic [DW-1:0]     wb_data;
  logic              wb_ack;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;

  modport slave (
    input  rd_req, rd_addr, wb_req, wb_addr, wb_data, mem_rdata,
    output rd_valid, rd_data, wb_ack, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd_req, rd_addr, wb_req, wb_addr, wb_data, mem_rdata,
    input  rd_valid, rd_data, wb_ack, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/snn_arb_pick.sv
// Combinational grant decision between the read port and the write-back port.
// Write-back wins unless a read has already waited through STARVE_MAX write grants.
module snn_arb_pick
  import snn_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int SW         = cnt_w(STARVE_MAX)
) (
  input  logic          i_rd_req,
  input  logic          i_wb_req,
  input  logic          i_rd_mask,
  input  logic          i_wb_mask,
  input  logic [SW-1:0] i_wb_streak,
  output logic          o_gnt_rd,
  output logic          o_gnt_wb
);

  logic w_rd_live;
  logic w_starved;

  assign w_rd_live = i_rd_req && !i_rd_mask;
  assign w_starved = (i_wb_streak >= SW'(STARVE_MAX));

  assign o_gnt_wb = i_wb_req && !i_wb_mask && (!w_rd_live || !w_starved);
  assign o_gnt_rd = w_rd_live && !o_gnt_wb;

endmodule

// File: rtl/snn_mem_arbiter.sv
// Weight-memory arbiter: forwards host writes in phase 0, serialises Multilayer reads and
// write-backs in phase 1, and generates the Multilayer start pulse. Define SNN_ARB_STALL_CNT_EN for stall_cnt.
module snn_mem_arbiter
  import snn_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DW         = DW_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_phase_infer,
  input  logic              i_done,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DW-1:0]     i_host_wdata,
  snn_mem_arbiter_if.slave  bus,
  output logic              o_start,
  output logic              o_busy,
  output logic [15:0]       o_stall_cnt
);

  localparam int SW    = cnt_w(STARVE_MAX);
  localparam int LAT_W = cnt_w(RD_LAT - 1);

  arb_state_t        r_state;
  logic [SW-1:0]     r_wb_streak;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic              r_rd_mask;
  logic              r_wb_mask;
  logic              r_phase_q;

  logic              r_rd_valid;
  logic [DW-1:0]     r_rd_data;
  logic              r_wb_ack;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DW-1:0]     r_mem_wdata;
  logic              r_start;
  logic              r_busy;

  logic              w_gnt_rd;
  logic              w_gnt_wb;
  logic              w_idle;
  logic [SW-1:0]     w_streak_inc;

  assign w_idle       = (r_state == IDLE);
  assign w_streak_inc = (r_wb_streak >= SW'(STARVE_MAX)) ? r_wb_streak : r_wb_streak + 1'b1;

  snn_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .i_rd_req    (bus.rd_req),
    .i_wb_req    (bus.wb_req),
    .i_rd_mask   (r_rd_mask),
    .i_wb_mask   (r_wb_mask),
    .i_wb_streak (r_wb_streak),
    .o_gnt_rd    (w_gnt_rd),
    .o_gnt_wb    (w_gnt_wb)
  );

  // NOTE: every register here uses <= so all branches see pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wb_streak <= '0;
      r_lat_cnt   <= '0;
      r_rd_mask   <= 1'b0;
      r_wb_mask   <= 1'b0;
      r_phase_q   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_wb_ack    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_phase_q  <= i_phase_infer;
      r_rd_valid <= 1'b0;
      r_wb_ack   <= 1'b0;
      r_start    <= 1'b0;

      if (!i_phase_infer) begin
        // Host owns the memory; anything in flight is abandoned without a response.
        r_mem_we    <= i_host_we;
        r_mem_addr  <= i_host_addr;
        r_mem_wdata <= i_host_wdata;
        r_state     <= IDLE;
        r_wb_streak <= '0;
        r_rd_mask   <= 1'b0;
        r_wb_mask   <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        r_start  <= !r_phase_q || i_done;
        r_mem_we <= 1'b0;

        unique case (r_state)
          IDLE: begin
            r_rd_mask <= 1'b0;
            r_wb_mask <= 1'b0;
            if (w_gnt_wb) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= bus.wb_addr;
              r_mem_wdata <= bus.wb_data;
              // The streak only counts grants that actually make a read wait.
              r_wb_streak <= bus.rd_req ? w_streak_inc : '0;
              r_state     <= WB_RESP;
              r_busy      <= 1'b1;
            end else if (w_gnt_rd) begin
              r_mem_addr  <= bus.rd_addr;
              r_wb_streak <= '0;
              r_lat_cnt   <= LAT_W'(RD_LAT - 1);
              r_state     <= RD_WAIT;
              r_busy      <= 1'b1;
            end else if (!bus.rd_req) begin
              r_wb_streak <= '0;
            end
          end

          RD_WAIT: begin
            if (r_lat_cnt == '0) begin
              r_state <= RD_RESP;
            end else begin
              r_lat_cnt <= r_lat_cnt - 1'b1;
            end
          end

          RD_RESP: begin
            r_rd_data  <= bus.mem_rdata;
            r_rd_valid <= 1'b1;
            r_rd_mask  <= 1'b1;
            r_state    <= IDLE;
            r_busy     <= 1'b0;
          end

          WB_RESP: begin
            r_wb_ack  <= 1'b1;
            r_wb_mask <= 1'b1;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end

          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SNN_ARB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (!i_phase_infer) begin
      r_stall_cnt <= '0;
    end else if (bus.rd_req && w_idle && !w_gnt_rd && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = 16'd0;
`endif

  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.wb_ack    = r_wb_ack;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_start       = r_start;
  assign o_busy        = r_busy;

endmodule
